// File: rtl/inst_loader.sv
// Boot-time instruction loader: turns a length-prefixed little-endian byte stream
// into instruction RAM writes and holds the core in reset until the image is in.
module inst_loader #(
    parameter int w = 32,
    parameter int h = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         is_write,
    output logic [w-1:0] im_addr,
    output logic [w-1:0] im_inst,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         core_hold,
    output logic [h:0]   word_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(2**h);

    state_t       state_q, state_d;
    logic [15:0]  len_q, len_d;
    logic [1:0]   lane_q, lane_d;
    logic [23:0]  buf_q, buf_d;
    logic         wr_q, wr_d;
    logic [w-1:0] addr_q, addr_d;
    logic [w-1:0] inst_q, inst_d;
    logic [h:0]   cnt_q, cnt_d;
    logic         done_q, done_d;

    logic         accept;
    logic [15:0]  len_full;
    logic [16:0]  cnt_inc;

    assign rx_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign busy      = rx_ready;
    assign accept    = rx_valid && rx_ready;
    assign len_full  = {rx_data, len_q[7:0]};
    assign cnt_inc   = 17'(cnt_q) + 17'd1;

    assign is_write  = wr_q;
    assign im_addr   = addr_q;
    assign im_inst   = inst_q;
    assign word_cnt  = cnt_q;
    assign done      = done_q;
    assign err       = (state_q == ERR);
    assign core_hold = ~done_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                // done rises one cycle after DONE is entered so the last write has retired
                done_d = (state_q == DONE) && !start;
                if (start) begin
                    state_d = LEN_LO;
                    cnt_d   = '0;
                    lane_d  = '0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: buf_d[7:0]   = rx_data;
                        2'd1: buf_d[15:8]  = rx_data;
                        2'd2: buf_d[23:16] = rx_data;
                        default: begin
                            wr_d   = 1'b1;
                            inst_d = w'({rx_data, buf_q});
                            addr_d = w'(cnt_q) << 2;
                            cnt_d  = cnt_inc[h:0];
                            if (cnt_inc == {1'b0, len_q}) begin
                                state_d = DONE;
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            lane_q  <= '0;
            buf_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed and randomized byte streams compared against
// an image model that decodes the stream format directly.
module tb_inst_loader;

    localparam int W = 32;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         rst, start, rx_valid;
    logic [7:0]   rx_data;
    logic         rx_ready, is_write, busy, done, err, core_hold;
    logic [W-1:0] im_addr, im_inst;
    logic [H:0]   word_cnt;

    inst_loader #(.w(W), .h(H)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .is_write(is_write), .im_addr(im_addr), .im_inst(im_inst),
        .busy(busy), .done(done), .err(err), .core_hold(core_hold), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    byte unsigned stream_q[$];
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    bit          exp_err;
    int          exp_len;

    always @(negedge clk) if (is_write === 1'b1) wr_q.push_back({im_addr, im_inst});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            acc = rx_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL byte_accept: byte %h not accepted within 50 cycles, rx_ready=%b", b, rx_ready);
        end
    endtask

    task automatic send_range(input int first, input int last, input int max_gap);
        for (int i = first; i <= last; i++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            send_byte(stream_q[i]);
        end
    endtask

    // Decode the stream as a whole: header length, then one word per 4 bytes.
    task automatic model();
        exp_q.delete();
        exp_len = int'(stream_q[0]) + 256 * int'(stream_q[1]);
        exp_err = exp_len > (1 << H);
        if (!exp_err)
            for (int i = 0; i < exp_len; i++)
                exp_q.push_back({32'(i * 4), stream_q[2+4*i+3], stream_q[2+4*i+2],
                                 stream_q[2+4*i+1], stream_q[2+4*i]});
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        tests_run++;
        if ({rx_ready, is_write, busy, done, err, core_hold} !== 6'b000001) begin
            tests_failed++;
            $display("FAIL reset_flags: got rdy/wr/busy/done/err/hold=%b expected 000001",
                     {rx_ready, is_write, busy, done, err, core_hold});
        end
        tests_run++;
        if ({im_addr, im_inst, word_cnt} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got addr=%h inst=%h cnt=%0d expected all zero", im_addr, im_inst, word_cnt);
        end
    endtask

    task automatic test_two_word();
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        wr_q.delete();
        pulse_start();
        send_range(0, 9, 0);
        tests_run++;
        if ({is_write, im_addr, im_inst, word_cnt, done} !== {1'b1, 32'd4, 32'h00100093, 9'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL two_word_last_write: got wr=%b addr=%h inst=%h cnt=%0d done=%b expected 1/4/00100093/2/0",
                     is_write, im_addr, im_inst, word_cnt, done);
        end
        tick();
        tests_run++;
        if ({is_write, done, core_hold, im_addr, im_inst} !== {3'b010, 32'd4, 32'h00100093}) begin
            tests_failed++;
            $display("FAIL two_word_done: got wr=%b done=%b hold=%b addr=%h inst=%h expected 0/1/0/4/00100093",
                     is_write, done, core_hold, im_addr, im_inst);
        end
        tests_run++;
        if (wr_q.size() != 2 || wr_q[0] !== {32'd0, 32'h00000013} || wr_q[1] !== {32'd4, 32'h00100093}) begin
            tests_failed++;
            $display("FAIL two_word_sequence: got %0d writes, first=%h expected 0000000000000013,0000000400100093",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'hx);
        end
    endtask

    task automatic test_zero_len();
        wr_q.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        tests_run++;
        if ({done, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_len_early: got done=%b busy=%b expected 0/0", done, busy);
        end
        tick();
        tests_run++;
        if ({done, err, core_hold, 32'(wr_q.size())} !== {3'b100, 32'd0}) begin
            tests_failed++;
            $display("FAIL zero_len: got done=%b err=%b hold=%b writes=%0d expected 1/0/0/0",
                     done, err, core_hold, wr_q.size());
        end
    endtask

    task automatic test_oversize();
        wr_q.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        repeat (3) tick();
        tests_run++;
        if ({err, rx_ready, done, core_hold, busy, 32'(wr_q.size())} !== {5'b10010, 32'd0}) begin
            tests_failed++;
            $display("FAIL oversize: got err=%b rdy=%b done=%b hold=%b busy=%b writes=%0d expected 1/0/0/1/0/0",
                     err, rx_ready, done, core_hold, busy, wr_q.size());
        end
    endtask

    task automatic test_throttled();
        int busy_low;
        busy_low = 0;
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        model();
        wr_q.delete();
        pulse_start();
        foreach (stream_q[i]) begin
            repeat (2) begin
                if (busy !== 1'b1) busy_low++;
                tick();
            end
            send_byte(stream_q[i]);
        end
        tick();
        tests_run++;
        if (busy_low != 0) begin
            tests_failed++;
            $display("FAIL throttled_busy: got %0d idle cycles with busy low expected 0", busy_low);
        end
        tests_run++;
        if (wr_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL throttled_count: got %0d writes expected %0d", wr_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests_run++;
                if (wr_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL throttled_write%0d: got %h expected %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if ({done, word_cnt} !== {1'b1, 9'd2}) begin
            tests_failed++;
            $display("FAIL throttled_done: got done=%b cnt=%0d expected 1/2", done, word_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        stream_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pulse_start();
        send_range(0, 7, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({rx_ready, is_write, busy, done, err, core_hold, im_addr, im_inst, word_cnt} !== {6'b000001, 73'd0}) begin
            tests_failed++;
            $display("FAIL reset_mid_load: got rdy/wr/busy/done/err/hold=%b addr=%h inst=%h cnt=%0d expected 000001/0/0/0",
                     {rx_ready, is_write, busy, done, err, core_hold}, im_addr, im_inst, word_cnt);
        end
        stream_q = '{8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        model();
        wr_q.delete();
        pulse_start();
        send_range(0, 5, 0);
        repeat (2) tick();
        tests_run++;
        if (wr_q.size() != 1 || wr_q[0] !== exp_q[0] || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_after_reset: got %0d writes first=%h done=%b expected 1 write %h done=1",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'hx, done, exp_q[0]);
        end
    endtask

    task automatic test_start_during_load();
        stream_q = '{8'h03, 8'h00};
        repeat (12) stream_q.push_back(8'($urandom));
        model();
        wr_q.delete();
        pulse_start();
        send_range(0, 6, 0);
        pulse_start();
        pulse_start();
        tests_run++;
        if ({busy, word_cnt} !== {1'b1, 9'd1}) begin
            tests_failed++;
            $display("FAIL start_while_busy: got busy=%b cnt=%0d expected 1/1", busy, word_cnt);
        end
        send_range(7, 13, 0);
        repeat (2) tick();
        tests_run++;
        if (wr_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL start_while_busy_count: got %0d writes expected %0d", wr_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests_run++;
                if (wr_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL start_while_busy_write%0d: got %h expected %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    // Random images with random byte gaps, ending with the largest legal image.
    task automatic test_random_images();
        for (int it = 0; it < 7; it++) begin
            int n;
            n = (it == 6) ? (1 << H) : int'($urandom_range(8, 1));
            stream_q = '{8'(n), 8'(n >> 8)};
            repeat (4 * n) stream_q.push_back(8'($urandom));
            model();
            wr_q.delete();
            pulse_start();
            send_range(0, stream_q.size() - 1, (it == 6) ? 0 : 3);
            repeat (2) tick();
            tests_run++;
            if (wr_q.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL random%0d_count: got %0d writes expected %0d", it, wr_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    tests_run++;
                    if (wr_q[i] !== exp_q[i]) begin
                        tests_failed++;
                        $display("FAIL random%0d_write%0d: got %h expected %h", it, i, wr_q[i], exp_q[i]);
                    end
                end
            end
            tests_run++;
            if ({done, err, core_hold, word_cnt} !== {!exp_err, exp_err, exp_err, 9'(exp_len)}) begin
                tests_failed++;
                $display("FAIL random%0d_status: got done=%b err=%b hold=%b cnt=%0d expected %b/%b/%b/%0d",
                         it, done, err, core_hold, word_cnt, !exp_err, exp_err, exp_err, exp_len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_zero_len();
        test_oversize();
        test_throttled();
        test_reset_mid_load();
        test_start_during_load();
        test_random_images();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time loader that sits directly upstream of the instruction RAM.
- Accepts a byte stream (e.g. from the UART receiver) and assembles little-endian 32-bit instruction words.
- Drives the RAM write port (is_write, im_addr, im_inst) and holds the core in reset until the image is loaded.
- Stream format: 16-bit word count (LSB first), then count×4 instruction bytes.

Parameters:
- w, 32, data/address width; matches the instruction RAM word width.
- h, 8, log2 of instruction RAM depth in words; maximum image is 2**h words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid & rx_ready.
- is_write  out  1  instruction RAM write strobe, one cycle per word.
- im_addr  out  w  byte address of the word being written; always a multiple of 4.
- im_inst  out  w  assembled instruction word.
- busy  out  1  load in progress.
- done  out  1  image fully written; sticky until start or rst.
- err  out  1  length exceeds RAM depth; sticky until start or rst.
- core_hold  out  1  holds the core in reset; high whenever done=0.
- word_cnt  out  h+1  number of words written so far.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - rx_ready=0, is_write=0, im_addr=0, im_inst=0, busy=0, done=0, err=0, word_cnt=0, core_hold=1.
  - Byte lane counter = 0; state = IDLE.
- States:
  - IDLE: rx_ready=0.
    - start → LEN_LO; clear word_cnt, lane counter, err, done.
  - LEN_LO: rx_ready=1. Accept byte → len[7:0]; go to LEN_HI.
  - LEN_HI: rx_ready=1. Accept byte → len[15:8], then:
    - if {byte,len[7:0]} == 0 → DONE;
    - else if > 2**h → ERR;
    - else → DATA.
  - DATA: rx_ready=1.
    - Each accepted byte fills lane k (bits 8k+7:8k), k = 0..3; k increments and wraps 3→0.
    - On the 4th byte, a write is issued next cycle: is_write=1, im_inst = assembled word, im_addr = word_cnt<<2.
    - word_cnt increments in that same write cycle.
    - If that byte completes word len-1 → DONE.
    - Byte acceptance continues back-to-back: a byte may be accepted in the same cycle as the write pulse.
  - DONE: rx_ready=0, busy=0.
    - done=1 from the cycle after DONE is entered, so the final write has retired before done rises.
    - core_hold = ~done.
    - start → LEN_LO (reload).
  - ERR: rx_ready=0, busy=0, err=1, no writes. start → LEN_LO.
- Common output rules:
  - busy=1 in LEN_LO, LEN_HI and DATA.
  - is_write is a single-cycle pulse; im_addr and im_inst hold their last values when is_write=0.
- Latency: last byte of a word accepted at edge N → is_write high in cycle N+1.
- Address wrap: cannot occur; the length check guarantees im_addr ≤ (2**h−1)×4.
- rx_valid gaps: any number of idle cycles between bytes is legal; no timeout.
- start while busy: ignored.
- rst mid-load: everything returns to reset values and the partial word is discarded. Words already written stay in RAM, but done stays 0.
- rst and start in the same cycle: rst wins.

Test Plan:
- Two-word image: stream 02 00 | 13 00 00 00 | 93 00 10 00, rx_valid continuous.
  → is_write pulses with (im_addr=0, im_inst=00000013), then (im_addr=4, im_inst=00100093).
  → word_cnt=2; done=1 one cycle after the second write; core_hold=0.
- Zero-length image: stream 00 00 → no is_write; done=1 two cycles after LEN_HI acceptance; err=0.
- Oversize image: h=8, stream 01 01 (257 words) → err=1, rx_ready=0, no is_write, done=0, core_hold=1.
- Throttled source: same two-word stream with rx_valid high every third cycle → identical write sequence and values; busy=1 throughout.
- Reset mid-load: rst pulsed after 6 data bytes → all outputs at reset values. A new start with a one-word stream 01 00 | 6F 00 00 00 → single write (addr 0, data 0000006F), done=1.
- Start during load: start pulsed while in DATA → no effect on state, word_cnt or write sequence.
